// File: rtl/dir_controller.sv
// dir_controller: turns four raw push-buttons into the 2-bit movement direction
// for snake_head. Each button is synchronised, debounced and edge-detected;
// no-op turns and 180-degree reversals are rejected, and up to two turns queue
// so a fast double turn spans two movement ticks.
//
// Ports:
//   clk, reset            system clock, asynchronous active-high reset
//   btn_up/right/down/left raw asynchronous active-high buttons
//   tick                  one-cycle movement strobe shared with snake_head
//   dir                   registered direction: 00 up, 01 right, 10 down, 11 left
//   dir_changed           one-cycle pulse, high while dir shows a freshly updated value
//   pending               number of queued turns (0..2)
module dir_controller #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_BITS        = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_right,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       tick,
    output logic [1:0] dir,
    output logic       dir_changed,
    output logic [1:0] pending
);

    // Bit index of each button equals its direction code.
    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_LEFT  = 2'b11;

    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(DEBOUNCE_CYCLES - 1);

    logic [3:0]          raw;
    logic [3:0]          sync1;
    logic [3:0]          sync2;
    logic [3:0]          stable;
    logic [3:0]          stable_d;
    logic [CNT_BITS-1:0] cnt [4];
    logic [3:0]          press;

    logic                ev_vld;
    logic [1:0]          ev_dir;
    logic [1:0]          ref_dir;
    logic                accept;

    logic                lock;
    logic [1:0]          q0;
    logic [1:0]          q1;

    assign raw = {btn_left, btn_down, btn_right, btn_up};

    // ------------------------------------------------------------------
    // Synchroniser + debounce, one lane per button.
    // The counter only runs while the synchronised input disagrees with the
    // debounced state; any agreeing cycle restarts it, so a bounce shorter
    // than DEBOUNCE_CYCLES never flips stable.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1    <= '0;
            sync2    <= '0;
            stable   <= '0;
            stable_d <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            stable_d <= stable;
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    stable[i] <= ~stable[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Rising edge of the debounced state only; releases are ignored.
    assign press = stable & ~stable_d;

    // One press per cycle, fixed priority up > right > down > left.
    always_comb begin
        ev_vld = |press;
        ev_dir = DIR_UP;
        if (press[0]) begin
            ev_dir = DIR_UP;
        end else if (press[1]) begin
            ev_dir = DIR_RIGHT;
        end else if (press[2]) begin
            ev_dir = DIR_DOWN;
        end else if (press[3]) begin
            ev_dir = DIR_LEFT;
        end
    end

    // A press is judged against where the snake will be heading once every
    // queued turn has been applied, not against the current dir.
    always_comb begin
        ref_dir = dir;
        if (pending == 2'd2) begin
            ref_dir = q1;
        end else if (pending == 2'd1) begin
            ref_dir = q0;
        end
    end

    // Flipping bit 1 of a direction code yields its opposite.
    assign accept = ev_vld && (ev_dir != ref_dir) && (ev_dir != (ref_dir ^ 2'b10));

    // ------------------------------------------------------------------
    // Direction / queue state.
    // lock marks that dir already moved during the current tick interval,
    // so further turns must wait in the queue for the next tick.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dir         <= DIR_RIGHT;
            dir_changed <= 1'b0;
            pending     <= 2'd0;
            lock        <= 1'b0;
            q0          <= DIR_UP;
            q1          <= DIR_UP;
        end else begin
            dir_changed <= 1'b0;
            if (tick) begin
                if (pending != 2'd0) begin
                    // Pop the head; the pop always frees a slot for a new press.
                    dir         <= q0;
                    dir_changed <= 1'b1;
                    lock        <= 1'b1;
                    if (pending == 2'd2) begin
                        q0 <= q1;
                        if (accept) begin
                            q1 <= ev_dir;
                        end else begin
                            pending <= 2'd1;
                        end
                    end else begin
                        if (accept) begin
                            q0 <= ev_dir;
                        end else begin
                            pending <= 2'd0;
                        end
                    end
                end else begin
                    lock <= 1'b0;
                    if (accept) begin
                        dir         <= ev_dir;
                        dir_changed <= 1'b1;
                        lock        <= 1'b1;
                    end
                end
            end else if (accept) begin
                if (!lock && (pending == 2'd0)) begin
                    dir         <= ev_dir;
                    dir_changed <= 1'b1;
                    lock        <= 1'b1;
                end else if (pending == 2'd0) begin
                    q0      <= ev_dir;
                    pending <= 2'd1;
                end else if (pending == 2'd1) begin
                    q1      <= ev_dir;
                    pending <= 2'd2;
                end
                // Queue full: the press is dropped.
            end
        end
    end

    // DIR_DOWN / DIR_LEFT are documented codes; reference them so the
    // encoding table stays next to the logic that relies on it.
    logic unused_codes;
    assign unused_codes = ^{DIR_DOWN, DIR_LEFT};

endmodule
